// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's control inputs, instruction-memory port and IF/ID outputs.
// master = fetch unit side, slave = pipeline/memory side.
interface fetch_unit_if;
  logic [1:0]  pc_sel;
  logic [31:0] jal_target;
  logic [31:0] br_target;
  logic        stall;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  modport master (
    input  pc_sel, jal_target, br_target, stall, imem_dout,
    output imem_en, imem_addr, if_pc, if_instr, if_valid, misalign_err, fetch_cnt
  );

  modport slave (
    output pc_sel, jal_target, br_target, stall, imem_dout,
    input  imem_en, imem_addr, if_pc, if_instr, if_valid, misalign_err, fetch_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection with redirect/stall handling,
// synchronous instruction-memory addressing and a count of instructions accepted by ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        misalign_q, misalign_d;
  logic        redirect;
  logic [31:0] target;
  logic        valid;

  // pc_sel==11 is reserved and falls through to sequential fetch.
  always_comb begin
    redirect = (bus.pc_sel == 2'b01) || (bus.pc_sel == 2'b10);
    target   = (bus.pc_sel == 2'b10) ? bus.br_target : bus.jal_target;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    misalign_d    = misalign_q;
    fetch_cnt_d   = fetch_cnt_q;
    valid         = 1'b0;
    bus.imem_en   = 1'b0;
    bus.imem_addr = RESET_PC;
    case (state_q)
      ST_RESET: begin
        state_d = ST_PRIME;
      end
      ST_PRIME: begin
        bus.imem_en   = 1'b1;
        bus.imem_addr = RESET_PC;
        pc_d          = RESET_PC;
        state_d       = ST_RUN;
      end
      ST_RUN: begin
        bus.imem_en = 1'b1;
        // The slot being presented is wrong-path whenever we redirect.
        valid = !redirect;
        if (redirect) begin
          pc_d = {target[31:2], 2'b00};
          if (target[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end
        end else if (!bus.stall) begin
          pc_d = pc_q + 32'd4;
        end
        bus.imem_addr = pc_d;
        if (valid && !bus.stall) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      pc_q        <= RESET_PC;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      misalign_q  <= misalign_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Memory data is not reset: the PRIME cycle never presents it as valid.
  assign bus.if_valid     = valid;
  assign bus.if_pc        = pc_q;
  assign bus.if_instr     = bus.imem_dout;
  assign bus.misalign_err = misalign_q;
  assign bus.fetch_cnt    = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, async-reset sequences and
// randomized traffic checked against a cycle-counting behavioural model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous-read instruction memory: data for the address issued now appears next cycle.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_dout <= mem_word(bus.imem_addr);
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: edges counted since reset release, current fetch PC, error flag, count.
  bit          m_in_rst;
  int          m_edges;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_redirect(input logic [1:0] s);
    return (s == 2'd1) || (s == 2'd2);
  endfunction

  function automatic logic [31:0] chosen_target(input logic [1:0] s, input logic [31:0] j,
                                                input logic [31:0] b);
    return (s == 2'd2) ? b : j;
  endfunction

  task automatic check_model();
    bit          run, prime, redir;
    logic [31:0] exp_addr;
    run   = !m_in_rst && (m_edges >= 2);
    prime = !m_in_rst && (m_edges == 1);
    redir = is_redirect(bus.pc_sel);
    if (run) begin
      if (redir) exp_addr = chosen_target(bus.pc_sel, bus.jal_target, bus.br_target) & ~32'd3;
      else if (bus.stall) exp_addr = m_pc;
      else exp_addr = m_pc + 32'd4;
    end else begin
      exp_addr = RST_PC;
    end
    chk("imem_en",   {31'd0, bus.imem_en},  {31'd0, run || prime});
    chk("imem_addr", bus.imem_addr,         exp_addr);
    chk("if_valid",  {31'd0, bus.if_valid}, {31'd0, run && !redir});
    chk("if_pc",     bus.if_pc,             m_pc);
    chk("misalign",  {31'd0, bus.misalign_err}, {31'd0, m_err});
    chk("fetch_cnt", bus.fetch_cnt,         m_cnt);
    if (run) chk("if_instr", bus.if_instr, mem_word(m_pc));
  endtask

  task automatic model_edge();
    logic [31:0] t;
    if (m_in_rst) return;
    if (m_edges < 2) begin
      m_edges++;
      m_pc = RST_PC;
      return;
    end
    if (!is_redirect(bus.pc_sel) && !bus.stall) m_cnt = m_cnt + 32'd1;
    if (is_redirect(bus.pc_sel)) begin
      t = chosen_target(bus.pc_sel, bus.jal_target, bus.br_target);
      if (t % 4 != 0) m_err = 1'b1;
      m_pc = t - (t % 4);
    end else if (!bus.stall) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] jal, input logic [31:0] br,
                       input logic st);
    bus.pc_sel     = sel;
    bus.jal_target = jal;
    bus.br_target  = br;
    bus.stall      = st;
    #2;
    $display("cyc %0d rst_n=%0b sel=%0d stall=%0b addr=%h pc=%h valid=%0b cnt=%0d err=%0b",
             cyc, rst_n, sel, st, bus.imem_addr, bus.if_pc, bus.if_valid, bus.fetch_cnt,
             bus.misalign_err);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic step(input logic [1:0] sel, input logic [31:0] jal, input logic [31:0] br,
                      input logic st);
    drive(sel, jal, br, st);
    advance();
  endtask

  task automatic model_reset();
    m_in_rst = 1'b1;
    m_edges  = 0;
    m_pc     = RST_PC;
    m_err    = 1'b0;
    m_cnt    = 32'd0;
  endtask

  // Called at a negedge; releases reset so the next posedge enters PRIME.
  task automatic release_reset();
    rst_n    = 1'b1;
    m_in_rst = 1'b0;
    m_edges  = 0;
    step(2'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks the asynchronous effect.
  task automatic reset_mid();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_en",    {31'd0, bus.imem_en},  32'd0);
    chk("async_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("async_cnt",   bus.fetch_cnt,         32'd0);
    chk("async_err",   {31'd0, bus.misalign_err}, 32'd0);
    chk("async_addr",  bus.imem_addr,         RST_PC);
    @(negedge clk);
    cyc++;
    step(2'd0, 32'd0, 32'd0, 1'b0);
    step(2'd1, 32'h0000_0103, 32'd0, 1'b1);
    release_reset();
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] jal;
    logic [31:0] br;
    logic        stall;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        err;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] r, jt, bt;
    logic [1:0]  sel;

    // Rows start at the PRIME cycle; expected values are those seen before the clock edge.
    tbl[0]  = '{2'd0, 32'd0, 32'd0,          1'b0, 32'h4000_0000, 1'b0, 32'h4000_0000, 32'd0, 1'b0};
    tbl[1]  = '{2'd0, 32'd0, 32'd0,          1'b0, 32'h4000_0004, 1'b1, 32'h4000_0000, 32'd0, 1'b0};
    tbl[2]  = '{2'd0, 32'd0, 32'd0,          1'b0, 32'h4000_0008, 1'b1, 32'h4000_0004, 32'd1, 1'b0};
    tbl[3]  = '{2'd2, 32'd0, 32'h4000_0100,  1'b0, 32'h4000_0100, 1'b0, 32'h4000_0008, 32'd2, 1'b0};
    tbl[4]  = '{2'd0, 32'd0, 32'd0,          1'b0, 32'h4000_0104, 1'b1, 32'h4000_0100, 32'd2, 1'b0};
    tbl[5]  = '{2'd2, 32'd0, 32'h4000_0010,  1'b0, 32'h4000_0010, 1'b0, 32'h4000_0104, 32'd3, 1'b0};
    tbl[6]  = '{2'd0, 32'd0, 32'd0,          1'b1, 32'h4000_0010, 1'b1, 32'h4000_0010, 32'd3, 1'b0};
    tbl[7]  = '{2'd0, 32'd0, 32'd0,          1'b1, 32'h4000_0010, 1'b1, 32'h4000_0010, 32'd3, 1'b0};
    tbl[8]  = '{2'd0, 32'd0, 32'd0,          1'b1, 32'h4000_0010, 1'b1, 32'h4000_0010, 32'd3, 1'b0};
    tbl[9]  = '{2'd0, 32'd0, 32'd0,          1'b0, 32'h4000_0014, 1'b1, 32'h4000_0010, 32'd3, 1'b0};
    tbl[10] = '{2'd0, 32'd0, 32'd0,          1'b0, 32'h4000_0018, 1'b1, 32'h4000_0014, 32'd4, 1'b0};
    tbl[11] = '{2'd1, 32'h4000_0202, 32'd0,  1'b1, 32'h4000_0200, 1'b0, 32'h4000_0018, 32'd5, 1'b0};
    tbl[12] = '{2'd0, 32'd0, 32'd0,          1'b0, 32'h4000_0204, 1'b1, 32'h4000_0200, 32'd5, 1'b1};
    tbl[13] = '{2'd2, 32'd0, 32'hFFFF_FFFC,  1'b0, 32'hFFFF_FFFC, 1'b0, 32'h4000_0204, 32'd6, 1'b1};
    tbl[14] = '{2'd0, 32'd0, 32'd0,          1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'd6, 1'b1};
    tbl[15] = '{2'd3, 32'h0000_0800, 32'h0000_0900, 1'b0, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'd7, 1'b1};
    tbl[16] = '{2'd0, 32'd0, 32'd0,          1'b0, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'd8, 1'b1};

    bus.pc_sel = 2'd0; bus.jal_target = 32'd0; bus.br_target = 32'd0; bus.stall = 1'b0;
    model_reset();
    @(negedge clk);
    step(2'd0, 32'd0, 32'd0, 1'b0);
    release_reset();

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].sel, tbl[i].jal, tbl[i].br, tbl[i].stall);
      chk("tbl_addr",  bus.imem_addr,              tbl[i].addr);
      chk("tbl_valid", {31'd0, bus.if_valid},      {31'd0, tbl[i].valid});
      chk("tbl_pc",    bus.if_pc,                  tbl[i].pc);
      chk("tbl_cnt",   bus.fetch_cnt,              tbl[i].cnt);
      chk("tbl_err",   {31'd0, bus.misalign_err},  {31'd0, tbl[i].err});
      advance();
    end

    // Asynchronous reset during RUN, then the power-on sequence must repeat.
    reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(tbl[i].sel, tbl[i].jal, tbl[i].br, tbl[i].stall);
      chk("rerun_addr",  bus.imem_addr,         tbl[i].addr);
      chk("rerun_valid", {31'd0, bus.if_valid}, {31'd0, tbl[i].valid});
      chk("rerun_pc",    bus.if_pc,             tbl[i].pc);
      advance();
    end
    drive(2'd0, 32'd0, 32'd0, 1'b0);
    chk("rerun_cnt2", bus.fetch_cnt, 32'd2);
    chk("rerun_err",  {31'd0, bus.misalign_err}, 32'd0);
    advance();

    for (int k = 0; k < 300; k++) begin
      if (k % 100 == 99) begin
        reset_mid();
      end else begin
        r = $urandom;
        jt = ($urandom_range(7) == 0) ? r : (r & ~32'd3);
        r = $urandom;
        bt = ($urandom_range(7) == 0) ? r : (r & ~32'd3);
        sel = 2'($urandom_range(3));
        if ($urandom_range(1) == 0) sel = 2'd0;
        step(sel, jt, bt, ($urandom_range(9) < 3));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
